// File: rtl/softmax_pkg.sv
// Shared types and helpers for the Approx-Softmax datapath controllers.
package softmax_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } hyb_sub_state_e;

    // Saturate the requested approximate-bit count at the operand width.
    function automatic int unsigned clamp_k(input int unsigned k, input int unsigned w);
        return (k > w) ? w : k;
    endfunction

endpackage

// File: rtl/exdcr_hyb.sv
// Hybrid full-subtractor cell: exact borrow when flag=1, majority borrow when flag=0.
module exdcr_hyb (
    input  logic x,
    input  logic y,
    input  logic bin,
    input  logic flag,
    output logic r,
    output logic bout
);

    logic bout_exact;
    logic bout_approx;

    assign r           = x ^ y ^ bin;
    assign bout_exact  = (~(x ^ y) & bin) | (~x & y);
    assign bout_approx = (x & y) | (x & bin) | (y & bin);
    assign bout        = flag ? bout_exact : bout_approx;

endmodule

// File: rtl/hyb_sub_serial_ctrl.sv
// Bit-serial subtract controller: one hybrid subtractor cell reused LSB-first over W bits.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | one bit per cycle through the cell, busy high
// DONE  | result held, out_valid high until out_ready
module hyb_sub_serial_ctrl
    import softmax_pkg::*;
#(
    parameter int W  = 16,
    parameter int KW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [KW-1:0] approx_k,
    input  logic          flush,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  diff,
    output logic          borrow_out
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    hyb_sub_state_e state;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   res_sh;
    logic [KW-1:0]  k_q;
    logic [IW-1:0]  idx;
    logic           brw;

    logic           cell_flag;
    logic           cell_r;
    logic           cell_bout;
    logic           last_bit;

    // Operands shift right each RUN cycle, so bit i is always at position 0.
    assign cell_flag = (int'(idx) >= int'(k_q));
    assign last_bit  = (idx == IW'(W - 1));

    exdcr_hyb u_cell (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (brw),
        .flag (cell_flag),
        .r    (cell_r),
        .bout (cell_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            k_q        <= '0;
            idx        <= '0;
            brw        <= 1'b0;
        end else if (flush) begin
            // Partial result is dropped; diff/borrow_out keep the last completed value.
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        k_q      <= KW'(clamp_k(int'(approx_k), W));
                        idx      <= '0;
                        brw      <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {cell_r, res_sh[W-1:1]};
                    brw    <= cell_bout;
                    if (last_bit) begin
                        diff       <= {cell_r, res_sh[W-1:1]};
                        borrow_out <= cell_bout;
                        busy       <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
